mips_mem_responder: RTL



---
 rtl/mips_mem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mips_mem_responder.sv
// Word-addressed data memory for a MIPS core, behind valid/ready request and response
// channels, with a fixed number of wait states inserted before each access.
module mips_mem_responder #(
  parameter int Data_Width  = 32,
  parameter int Addr_Bits   = 8,
  parameter int Wait_Cycles = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [Data_Width-1:0] req_addr,
  input  logic [Data_Width-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [Data_Width-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int       Depth     = 2 ** Addr_Bits;
  localparam logic [7:0] WaitInit = 8'(Wait_Cycles);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [Data_Width-1:0] addr_q, addr_d;
  logic [Data_Width-1:0] wdata_q, wdata_d;
  logic [Data_Width-1:0] rdata_q;
  logic                  err_q, err_d;

  logic [Data_Width-1:0] mem [Depth];

  logic                  in_range;
  logic [Addr_Bits-1:0]  mem_idx;
  logic                  mem_we;
  logic                  accept;

  assign in_range = (addr_q[Data_Width-1:Addr_Bits] == '0);
  assign mem_idx  = addr_q[Addr_Bits-1:0];
  assign accept   = req_valid && req_ready;

  // Writes are gated by rst so a reset landing on the ACCESS edge drops the store.
  assign mem_we = (state_q == ACCESS) && in_range && we_q && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WaitInit;
          state_d = (WaitInit != 8'd0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        err_d   = !in_range;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Registered read port; stores and out-of-range accesses return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state_q == ACCESS) begin
      rdata_q <= (in_range && !we_q) ? mem[mem_idx] : '0;
    end
  end

  // Backing store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
